// File: rtl/data_mem_ctrl.sv
// Load/store unit bus controller: turns EX-stage requests into single-beat bus transactions,
// formats load data, and reports misalignment and bus timeouts as one-cycle pulses.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stallreq,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait,
        StDone
    } state_t;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Request attributes kept for load formatting once the bus answers
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  lane_q, lane_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        addr_err_q, addr_err_d;
    logic        timeout_err_q, timeout_err_d;

    logic        misaligned;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata_rep;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        req_strb      = 4'b1111;
        req_wdata_rep = req_wdata;
        unique case (req_size)
            2'b00: begin
                req_strb      = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_strb      = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_strb      = 4'b1111;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        load_byte = bus_rdata[7:0];
        unique case (lane_q)
            2'd0:    load_byte = bus_rdata[7:0];
            2'd1:    load_byte = bus_rdata[15:8];
            2'd2:    load_byte = bus_rdata[23:16];
            default: load_byte = bus_rdata[31:24];
        endcase
        load_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (size_q)
            2'b00:   load_data = {{24{sign_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{sign_q & load_half[15]}}, load_half};
            default: load_data = bus_rdata;
        endcase
    end

    assign stallreq = ((state_q == StIdle) && req_valid && !misaligned) ||
                      (state_q == StAddr) || (state_q == StWait);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        size_d        = size_q;
        sign_d        = sign_q;
        lane_d        = lane_q;
        bus_we_d      = bus_we_q;
        bus_wstrb_d   = bus_wstrb_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        resp_rdata_d  = resp_rdata_q;
        resp_valid_d  = 1'b0;
        addr_err_d    = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                    end else begin
                        state_d     = StAddr;
                        we_d        = req_we;
                        size_d      = req_size;
                        sign_d      = req_sign;
                        lane_d      = req_addr[1:0];
                        bus_we_d    = req_we;
                        bus_wstrb_d = req_we ? req_strb : 4'b0000;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_wdata_d = req_wdata_rep;
                    end
                end
            end
            StAddr: begin
                if (bus_gnt) begin
                    state_d = StWait;
                    cnt_d   = 8'd0;
                end
            end
            StWait: begin
                // rvalid takes priority over an expiring counter
                if (bus_rvalid) begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : load_data;
                end else if (cnt_q == LastCnt) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        bus_req_d = (state_d == StAddr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            sign_q        <= 1'b0;
            lane_q        <= 2'b00;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_wstrb_q   <= 4'b0000;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            lane_q        <= lane_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            addr_err_q    <= addr_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_wstrb   = bus_wstrb_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign addr_err    = addr_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of single transactions plus timeout/reset/ignore sequences.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stallreq, resp_valid, addr_err, timeout_err;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stallreq(stallreq), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .addr_err(addr_err), .timeout_err(timeout_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  gnt_dly;
        logic        err;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (case %0d): got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic run_vec(input vec_t v);
        drive_req(v.we, v.size, v.sign, v.addr, v.wdata);
        #1;
        chk("stall_on_accept", 32'(stallreq), 32'(!v.err));
        tick();
        req_valid = 1'b0;
        #1;
        if (v.err) begin
            chk("addr_err_set", 32'(addr_err), 32'd1);
            chk("no_bus_req_err", 32'(bus_req), 32'd0);
            chk("no_stall_err", 32'(stallreq), 32'd0);
            tick();
            chk("addr_err_pulse", 32'(addr_err), 32'd0);
            chk("no_bus_req_err2", 32'(bus_req), 32'd0);
        end else begin
            chk("bus_req_addr", 32'(bus_req), 32'd1);
            chk("bus_addr", bus_addr, v.exp_baddr);
            chk("bus_wstrb", 32'(bus_wstrb), 32'(v.exp_strb));
            chk("bus_we", 32'(bus_we), 32'(v.we));
            if (v.we) chk("bus_wdata", bus_wdata, v.exp_wdata);
            for (int i = 0; i < int'(v.gnt_dly); i++) begin
                bus_rvalid = 1'b1;  // must be ignored while waiting for grant
                bus_rdata  = 32'hFFFF_FFFF;
                tick();
                chk("bus_req_held", 32'(bus_req), 32'd1);
                chk("bus_addr_stable", bus_addr, v.exp_baddr);
            end
            bus_rvalid = 1'b0;
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            #1;
            chk("bus_req_drop_wait", 32'(bus_req), 32'd0);
            chk("stall_in_wait", 32'(stallreq), 32'd1);
            chk("no_resp_in_wait", 32'(resp_valid), 32'd0);
            bus_rvalid = 1'b1;
            bus_rdata  = v.rdata;
            tick();
            bus_rvalid = 1'b0;
            bus_rdata  = 32'h0;
            #1;
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_rdata", resp_rdata, v.exp_rdata);
            chk("stall_in_done", 32'(stallreq), 32'd0);
            tick();
            chk("resp_valid_pulse", 32'(resp_valid), 32'd0);
            chk("resp_rdata_hold", resp_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        //          we    size   sg    addr           wdata          rdata          dly   err   baddr          strb     wdata_exp      rdata_exp
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 2'd0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'hDEAD_BEEF, 2'd0, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h0,        2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0,        32'h8001_7FFF, 2'd1, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0,        32'h1234_F00D, 2'd0, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'h0000_F00D};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0,        32'h1122_3344, 2'd0, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_0033};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_5002, 32'h0,        32'h0055_7F00, 2'd2, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_0055};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'hABCD_EF5A, 32'h1111_1111, 2'd0, 1'b0, 32'h0000_6000, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hCAFE_BABE, 32'h0,        2'd1, 1'b0, 32'h0000_7000, 4'b1111, 32'hCAFE_BABE, 32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b1, 32'h0000_8004, 32'h0,        32'h89AB_CDEF, 2'd2, 1'b0, 32'h0000_8004, 4'b0000, 32'h0,        32'h89AB_CDEF};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_9000, 32'h0,        32'h0,        2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_9001, 32'h0000_BEEF, 32'h0,        2'd0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_A000, 32'hFFFF_8765, 32'h0,        2'd0, 1'b0, 32'h0000_A000, 4'b0011, 32'h8765_8765, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        tick();
        tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_baddr", bus_addr, 32'd0);
        chk("rst_resp", 32'({resp_valid, addr_err, timeout_err, stallreq}), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Timeout: grant after two idle ADDR cycles, no rvalid ever
        cur = 100;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_C000, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("to_bus_req_held", 32'(bus_req), 32'd1);
            bus_gnt = (i == 2);
            tick();
        end
        bus_gnt = 1'b0;
        #1;
        chk("to_bus_req_drop", 32'(bus_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_not_yet", 32'(timeout_err), 32'd0);
            chk("to_stall", 32'(stallreq), 32'd1);
            tick();
        end
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_idle_stall", 32'(stallreq), 32'd0);
        chk("to_no_resp", 32'(resp_valid), 32'd0);
        tick();
        chk("to_err_pulse", 32'(timeout_err), 32'd0);

        // rvalid on the final WAIT cycle beats the timeout
        cur = 101;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_D000, 32'h0);
        tick();
        req_valid = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        repeat (3) tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BAD_F00D;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("race_resp", 32'(resp_valid), 32'd1);
        chk("race_no_to", 32'(timeout_err), 32'd0);
        chk("race_rdata", resp_rdata, 32'h0BAD_F00D);
        tick();

        // Reset during WAIT, late rvalid must be ignored
        cur = 102;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_E000, 32'h0);
        tick();
        req_valid = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        chk("rst_wait_stall", 32'(stallreq), 32'd0);
        chk("rst_wait_bus_req", 32'(bus_req), 32'd0);
        tick();
        bus_rvalid = 1'b0;
        chk("rst_wait_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_wait_rdata", resp_rdata, 32'd0);
        tick();
        chk("rst_wait_no_resp2", 32'(resp_valid), 32'd0);

        // req_valid during DONE is not accepted
        cur = 103;
        drive_req(1'b0, 2'b00, 1'b0, 32'h0000_F000, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_00A5;
        tick();
        bus_rvalid = 1'b0;
        chk("done_resp", 32'(resp_valid), 32'd1);
        chk("done_stall_with_req", 32'(stallreq), 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("done_req_ignored", 32'(bus_req), 32'd0);
        chk("done_rdata", resp_rdata, 32'h0000_00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
